instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/if_pkg.sv | 10 +
 rtl/fetch_queue.sv | 55 +++++
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared defaults for the instruction fetch unit: bus widths, the NOP encoding and the reset fetch address.
package if_pkg;

  localparam int unsigned IF_ADDR_W  = 8;
  localparam int unsigned IF_INSTR_W = 20;

  localparam logic [IF_INSTR_W-1:0] NOP_INSTR   = '0;
  localparam logic [IF_ADDR_W-1:0]  IF_RESET_PC = '0;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush. It holds the decoded-side instruction queue and the in-flight pc tags.
module fetch_queue #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 28,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_push_data,
  output logic [DATA_W-1:0] o_head_data,
  output logic              o_head_valid,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_pop;
  logic              w_do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset && !i_flush && w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_data  = r_mem[r_rd_ptr];
  assign o_head_valid = (r_count != '0);
  assign o_count      = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Credit-based instruction fetcher: issues in-order memory requests, tags them with their pc,
// queues returned instructions for decode and discards responses made stale by a redirect.
module instruction_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned          ADDR_W   = IF_ADDR_W,
  parameter int unsigned          INSTR_W  = IF_INSTR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(IF_RESET_PC),
  parameter int unsigned          QDEPTH   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               IF_ID_Hold,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid
);

  localparam int unsigned CNT_W   = $clog2(QDEPTH + 1);
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   r_drop;

  logic [CNT_W-1:0]   w_q_count;
  logic               w_q_valid;
  logic [ENTRY_W-1:0] w_q_head;
  logic [CNT_W-1:0]   w_tag_count;
  logic               w_tag_valid;
  logic [ADDR_W-1:0]  w_tag_pc;
  logic [SUM_W-1:0]   w_credits_used;
  logic               w_gnt;
  logic               w_rsp;
  logic               w_rsp_keep;
  logic               w_pop;
  logic [CNT_W-1:0]   w_out_next;
  logic               w_unused;

  // Credits cover both queued and in-flight instructions so a response always finds a free slot.
  assign w_credits_used = SUM_W'(w_q_count) + SUM_W'(r_outstanding);
  assign mem_req        = !reset && !branch_taken && (w_credits_used < SUM_W'(QDEPTH));
  assign mem_addr       = r_fetch_pc;

  assign w_gnt      = mem_req && mem_gnt;
  assign w_rsp      = mem_rvalid && (r_outstanding != '0);
  assign w_rsp_keep = w_rsp && (r_drop == '0) && w_tag_valid;
  assign w_pop      = w_q_valid && !IF_ID_Hold;
  assign w_out_next = r_outstanding + CNT_W'(w_gnt) - CNT_W'(w_rsp);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (branch_taken) begin
        r_fetch_pc <= branch_target;
        r_drop     <= w_out_next;
      end else begin
        if (w_gnt) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
      end
    end
  end

  // Pc of every live request, in issue order; stale requests are flushed out on a redirect.
  fetch_queue #(
    .DEPTH  (QDEPTH),
    .DATA_W (ADDR_W)
  ) u_tag_fifo (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_flush      (branch_taken),
    .i_push       (w_gnt),
    .i_pop        (w_rsp_keep),
    .i_push_data  (r_fetch_pc),
    .o_head_data  (w_tag_pc),
    .o_head_valid (w_tag_valid),
    .o_count      (w_tag_count)
  );

  fetch_queue #(
    .DEPTH  (QDEPTH),
    .DATA_W (ENTRY_W)
  ) u_instr_queue (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_flush      (branch_taken),
    .i_push       (w_rsp_keep),
    .i_pop        (w_pop),
    .i_push_data  ({w_tag_pc, mem_rdata}),
    .o_head_data  (w_q_head),
    .o_head_valid (w_q_valid),
    .o_count      (w_q_count)
  );

  assign instr_valid = w_q_valid;
  assign instruction = w_q_valid ? w_q_head[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
  assign instr_pc    = w_q_valid ? w_q_head[ENTRY_W-1:INSTR_W] : '0;

  assign w_unused = ^w_tag_count;

endmodule
